// File: rtl/uart_pkt_ctrl.sv
// Purpose : frames the UART receive byte stream (HDR, LEN, payload, XOR checksum) into command packets in a ping-pong buffer.
// Latency : pkt_vld/pkt_err rise one clk_40k cycle after the deciding rx_vld strobe; a stalled frame errors TIMEOUT cycles after its last byte.
// Backpressure: none -- every rx_vld strobe is consumed immediately; software reads the committed bank at its leisure until the next pkt_vld.
//
// Ports:
//   clk_40k, rst_n     : 40 kHz clock, asynchronous active-low reset
//   rx_vld, rx_data    : byte strobe and byte from the UART receiver
//   rd_addr, rd_data   : combinational read of the committed payload bank
//   pkt_len            : length of the last committed packet
//   pkt_vld, pkt_err   : one-cycle pulses for commit / drop
//   err_code           : cause of the last drop (1 length, 2 checksum, 3 timeout), held until the next drop
//   busy               : a frame is in progress
module uart_pkt_ctrl #(
  parameter logic [7:0] HDR     = 8'hA5,
  parameter int         MAX_LEN = 8,
  parameter int         TIMEOUT = 1200
) (
  input  logic       clk_40k,
  input  logic       rst_n,
  input  logic       rx_vld,
  input  logic [7:0] rx_data,
  input  logic [3:0] rd_addr,
  output logic [7:0] rd_data,
  output logic [3:0] pkt_len,
  output logic       pkt_vld,
  output logic       pkt_err,
  output logic [1:0] err_code,
  output logic       busy
);

  localparam int TW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LEN     = 2'd1,
    PAYLOAD = 2'd2,
    CSUM    = 2'd3
  } state_t;

  state_t          state;
  logic            bank;      // committed bank; the frame in progress writes ~bank
  logic [3:0]      len;
  logic [3:0]      idx;
  logic [7:0]      csum;
  logic [TW-1:0]   timer;

  // Two 16-byte banks, addressed as {bank, index}. No reset: contents are
  // meaningless until the first commit.
  logic [7:0]      mem [0:31];

  logic            len_bad;
  logic            timer_exp;

  assign len_bad   = (rx_data == 8'd0) || (rx_data > 8'(MAX_LEN));
  assign timer_exp = (timer == TW'(TIMEOUT - 1));

  // Committed bank only; the swap lands on the same edge as pkt_vld.
  assign rd_data = mem[{bank, rd_addr}];

  // Payload writes only ever target the working bank, so the committed
  // bank stays stable for the reader until the next commit.
  always_ff @(posedge clk_40k) begin
    if (rx_vld && state == PAYLOAD) begin
      mem[{~bank, idx}] <= rx_data;
    end
  end

  always_ff @(posedge clk_40k or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      bank     <= 1'b0;
      len      <= 4'd0;
      idx      <= 4'd0;
      csum     <= 8'd0;
      timer    <= '0;
      pkt_len  <= 4'd0;
      pkt_vld  <= 1'b0;
      pkt_err  <= 1'b0;
      err_code <= 2'd0;
      busy     <= 1'b0;
    end else begin
      pkt_vld <= 1'b0;
      pkt_err <= 1'b0;

      if (rx_vld) begin
        // A byte always restarts the inter-byte timer, even one arriving
        // in the very cycle the timer would have expired.
        timer <= '0;
        case (state)
          IDLE: begin
            // Anything other than a header is line noise between frames.
            if (rx_data == HDR) begin
              state <= LEN;
              busy  <= 1'b1;
            end
          end
          LEN: begin
            if (len_bad) begin
              pkt_err  <= 1'b1;
              err_code <= 2'd1;
              state    <= IDLE;
              busy     <= 1'b0;
            end else begin
              len   <= rx_data[3:0];
              csum  <= rx_data;
              idx   <= 4'd0;
              state <= PAYLOAD;
            end
          end
          PAYLOAD: begin
            // HDR bytes here are ordinary payload; no mid-frame resync.
            csum <= csum ^ rx_data;
            idx  <= idx + 4'd1;
            if (idx == len - 4'd1) begin
              state <= CSUM;
            end
          end
          CSUM: begin
            if (rx_data == csum) begin
              bank    <= ~bank;
              pkt_len <= len;
              pkt_vld <= 1'b1;
            end else begin
              pkt_err  <= 1'b1;
              err_code <= 2'd2;
            end
            state <= IDLE;
            busy  <= 1'b0;
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end else if (state != IDLE) begin
        if (timer_exp) begin
          pkt_err  <= 1'b1;
          err_code <= 2'd3;
          state    <= IDLE;
          busy     <= 1'b0;
          timer    <= '0;
        end else begin
          timer <= timer + TW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_pkt_ctrl.sv
// Purpose : self-checking bench for uart_pkt_ctrl using a frame-level reference model.
// Latency : outputs observed 1 time unit after each rising clk_40k edge.
// Backpressure: n/a -- the bench drives one-cycle rx_vld strobes.
module tb_uart_pkt_ctrl;

  localparam logic [7:0] HDR     = 8'hA5;
  localparam int         MAX_LEN = 8;
  localparam int         TIMEOUT = 1200;

  logic       clk_40k = 1'b0;
  logic       rst_n   = 1'b0;
  logic       rx_vld  = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic [3:0] rd_addr = 4'h0;
  logic [7:0] rd_data;
  logic [3:0] pkt_len;
  logic       pkt_vld;
  logic       pkt_err;
  logic [1:0] err_code;
  logic       busy;

  uart_pkt_ctrl #(.HDR(HDR), .MAX_LEN(MAX_LEN), .TIMEOUT(TIMEOUT)) dut (
    .clk_40k (clk_40k),
    .rst_n   (rst_n),
    .rx_vld  (rx_vld),
    .rx_data (rx_data),
    .rd_addr (rd_addr),
    .rd_data (rd_data),
    .pkt_len (pkt_len),
    .pkt_vld (pkt_vld),
    .pkt_err (pkt_err),
    .err_code(err_code),
    .busy    (busy)
  );

  always #10 clk_40k = ~clk_40k;

  int n_tests = 0;
  int n_fail  = 0;

  // Frame-level reference model: collect the bytes of the frame in
  // progress and judge the whole frame once enough bytes have arrived.
  logic [7:0] cur[$];
  logic [7:0] exp_pl[16];
  logic [3:0] exp_len  = 4'd0;
  logic [1:0] exp_code = 2'd0;
  logic       exp_vld  = 1'b0;
  logic       exp_err  = 1'b0;
  bit         any_commit = 1'b0;

  task automatic model_reset();
    cur.delete();
    exp_len = 4'd0; exp_code = 2'd0; exp_vld = 1'b0; exp_err = 1'b0;
    any_commit = 1'b0;
  endtask

  task automatic model_timeout();
    cur.delete();
    exp_code = 2'd3;
  endtask

  task automatic model_byte(input logic [7:0] b);
    logic [7:0] sum;
    exp_vld = 1'b0;
    exp_err = 1'b0;
    if (cur.size() == 0) begin
      if (b == HDR) cur.push_back(b);
    end else begin
      cur.push_back(b);
      if (cur.size() == 2 && (b == 8'd0 || int'(b) > MAX_LEN)) begin
        exp_err = 1'b1; exp_code = 2'd1; cur.delete();
      end else if (cur.size() > 2 && cur.size() == int'(cur[1]) + 3) begin
        sum = 8'd0;
        for (int i = 1; i < cur.size() - 1; i++) sum = sum ^ cur[i];
        if (sum == b) begin
          exp_vld = 1'b1;
          exp_len = cur[1][3:0];
          for (int i = 0; i < int'(cur[1]); i++) exp_pl[i] = cur[2 + i];
          any_commit = 1'b1;
        end else begin
          exp_err = 1'b1; exp_code = 2'd2;
        end
        cur.delete();
      end
    end
  endtask

  // One-cycle strobe; returns 1 time unit after the sampling edge.
  task automatic send_byte(input logic [7:0] b);
    rx_vld  = 1'b1;
    rx_data = b;
    @(posedge clk_40k); #1;
    rx_vld  = 1'b0;
  endtask

  task automatic drive(input logic [7:0] b);
    send_byte(b);
    model_byte(b);
  endtask

  task automatic read_at(input int a, output logic [7:0] d);
    rd_addr = 4'(a);
    #1;
    d = rd_data;
  endtask

  task automatic test_reset();
    n_tests++; if (pkt_len !== 4'd0) begin n_fail++; $display("FAIL reset_pkt_len: got %0d want 0", pkt_len); end
    n_tests++; if (err_code !== 2'd0) begin n_fail++; $display("FAIL reset_err_code: got %0d want 0", err_code); end
    n_tests++; if ({busy, pkt_vld, pkt_err} !== 3'b000) begin n_fail++; $display("FAIL reset_flags: busy/vld/err got %b want 000", {busy, pkt_vld, pkt_err}); end
    rst_n = 1'b1;
    model_reset();
    @(posedge clk_40k); #1;
    n_tests++; if ({busy, pkt_vld, pkt_err} !== 3'b000) begin n_fail++; $display("FAIL post_reset_flags: got %b want 000", {busy, pkt_vld, pkt_err}); end
  endtask

  task automatic test_good_packet();
    logic [7:0] f[6];
    logic [7:0] d;
    f = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h03};
    for (int i = 0; i < 5; i++) drive(f[i]);
    n_tests++; if ({busy, pkt_vld} !== 2'b10) begin n_fail++; $display("FAIL good_before_csum: busy/vld got %b want 10", {busy, pkt_vld}); end
    drive(f[5]);
    n_tests++; if (pkt_vld !== 1'b1) begin n_fail++; $display("FAIL good_vld: got %b want 1", pkt_vld); end
    n_tests++; if (pkt_len !== 4'd3) begin n_fail++; $display("FAIL good_len: got %0d want 3", pkt_len); end
    for (int i = 0; i < 3; i++) begin
      read_at(i, d);
      n_tests++; if (d !== f[2 + i]) begin n_fail++; $display("FAIL good_rd[%0d]: got %h want %h", i, d, f[2 + i]); end
    end
    @(posedge clk_40k); #1;
    n_tests++; if ({busy, pkt_vld, pkt_err} !== 3'b000) begin n_fail++; $display("FAIL good_pulse_width: busy/vld/err got %b want 000", {busy, pkt_vld, pkt_err}); end
  endtask

  task automatic test_bad_checksum();
    logic [7:0] d0, d1, d2;
    drive(8'hA5); drive(8'h02); drive(8'h10); drive(8'h20); drive(8'hFF);
    n_tests++; if ({pkt_err, pkt_vld, err_code} !== 4'b1010) begin n_fail++; $display("FAIL csum_err: err/vld/code got %b want 1010", {pkt_err, pkt_vld, err_code}); end
    n_tests++; if (pkt_len !== 4'd3) begin n_fail++; $display("FAIL csum_len_kept: got %0d want 3", pkt_len); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL csum_busy: got %b want 0", busy); end
    read_at(0, d0); read_at(1, d1); read_at(2, d2);
    n_tests++; if ({d0, d1, d2} !== 24'h112233) begin n_fail++; $display("FAIL csum_payload_kept: got %h want 112233", {d0, d1, d2}); end
  endtask

  task automatic test_bad_length();
    logic [7:0] d;
    drive(8'hA5); drive(8'h00);
    n_tests++; if ({pkt_err, err_code, busy} !== 4'b1010) begin n_fail++; $display("FAIL len0: err/code/busy got %b want 1010", {pkt_err, err_code, busy}); end
    drive(8'h5A);
    drive(8'hA5); drive(8'h09);
    n_tests++; if ({pkt_err, err_code, busy} !== 4'b1010) begin n_fail++; $display("FAIL len9: err/code/busy got %b want 1010", {pkt_err, err_code, busy}); end
    drive(8'hA5); drive(8'h01); drive(8'h7E); drive(8'h7F);
    n_tests++; if ({pkt_vld, pkt_len} !== 5'b1_0001) begin n_fail++; $display("FAIL len_recover: vld/len got %b want 10001", {pkt_vld, pkt_len}); end
    n_tests++; if (err_code !== 2'd1) begin n_fail++; $display("FAIL len_code_held: got %0d want 1", err_code); end
    read_at(0, d);
    n_tests++; if (d !== 8'h7E) begin n_fail++; $display("FAIL len_recover_rd: got %h want 7e", d); end
  endtask

  task automatic test_timeout();
    int  first = -1;
    logic [1:0] code_seen = 2'd0;
    bit  early = 1'b0;
    drive(8'hA5); drive(8'h04); drive(8'h01);
    for (int k = 1; k <= TIMEOUT + 4; k++) begin
      @(posedge clk_40k); #1;
      if (pkt_err === 1'b1 && first < 0) begin first = k; code_seen = err_code; end
    end
    model_timeout();
    n_tests++; if (first != TIMEOUT) begin n_fail++; $display("FAIL timeout_cycle: got %0d want %0d", first, TIMEOUT); end
    n_tests++; if (code_seen !== 2'd3) begin n_fail++; $display("FAIL timeout_code: got %0d want 3", code_seen); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL timeout_busy: got %b want 0", busy); end
    // Byte arriving in the expiry cycle must win.
    drive(8'hA5); drive(8'h04); drive(8'h01);
    for (int k = 1; k < TIMEOUT; k++) begin
      @(posedge clk_40k); #1;
      if (pkt_err !== 1'b0) early = 1'b1;
    end
    drive(8'h02);
    n_tests++; if ({early, pkt_err, busy} !== 3'b001) begin n_fail++; $display("FAIL timeout_byte_wins: early/err/busy got %b want 001", {early, pkt_err, busy}); end
    drive(8'h03); drive(8'h04); drive(8'h00);
    n_tests++; if ({pkt_vld, pkt_len, err_code} !== 7'b1_0100_11) begin n_fail++; $display("FAIL timeout_then_commit: vld/len/code got %b want 1010011", {pkt_vld, pkt_len, err_code}); end
  endtask

  task automatic test_pingpong();
    logic [7:0] d0, d1;
    drive(8'hA5); drive(8'h02); drive(8'hAA); drive(8'hBB); drive(8'h13);
    n_tests++; if ({pkt_vld, pkt_len} !== 5'b1_0010) begin n_fail++; $display("FAIL pp_commit: vld/len got %b want 10010", {pkt_vld, pkt_len}); end
    drive(8'hA5); drive(8'h02); drive(8'hCC);
    for (int s = 0; s < 4; s++) begin
      repeat (40) @(posedge clk_40k);
      #1;
      read_at(0, d0); read_at(1, d1);
      n_tests++; if ({d0, d1} !== 16'hAABB) begin n_fail++; $display("FAIL pp_stall[%0d]: got %h want aabb", s, {d0, d1}); end
    end
    drive(8'hDD);
    read_at(0, d0); read_at(1, d1);
    n_tests++; if ({d0, d1, busy} !== 17'h15577) begin n_fail++; $display("FAIL pp_full_write: rd/busy got %h want 15577", {d0, d1, busy}); end
    drive(8'h00);
    read_at(0, d0); read_at(1, d1);
    n_tests++; if ({pkt_err, err_code} !== 3'b110) begin n_fail++; $display("FAIL pp_bad_csum: err/code got %b want 110", {pkt_err, err_code}); end
    n_tests++; if ({d0, d1, pkt_len} !== 20'hAABB2) begin n_fail++; $display("FAIL pp_after_drop: rd/len got %h want aabb2", {d0, d1, pkt_len}); end
  endtask

  task automatic test_noise_reset();
    logic [7:0] d;
    logic [7:0] nz[3];
    bit pulsed = 1'b0;
    nz = '{8'h00, 8'hFF, 8'h5A};
    for (int i = 0; i < 3; i++) begin
      drive(nz[i]);
      n_tests++; if ({busy, pkt_vld, pkt_err} !== 3'b000) begin n_fail++; $display("FAIL noise[%0d]: busy/vld/err got %b want 000", i, {busy, pkt_vld, pkt_err}); end
    end
    drive(8'hA5); drive(8'h03); drive(8'h11); drive(8'h22);
    n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL mid_payload_busy: got %b want 1", busy); end
    rst_n = 1'b0;
    #1;
    model_reset();
    n_tests++; if ({pkt_len, err_code, busy, pkt_vld, pkt_err} !== 9'd0) begin n_fail++; $display("FAIL midframe_reset: len/code/busy/vld/err got %b want 0", {pkt_len, err_code, busy, pkt_vld, pkt_err}); end
    repeat (2) @(posedge clk_40k);
    #1;
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk_40k); #1;
      if (pkt_vld !== 1'b0 || pkt_err !== 1'b0 || busy !== 1'b0) pulsed = 1'b1;
    end
    n_tests++; if (pulsed !== 1'b0) begin n_fail++; $display("FAIL post_reset_quiet: activity seen %b want 0", pulsed); end
    drive(8'h33);
    drive(8'hA5); drive(8'h01); drive(8'h5A); drive(8'h5B);
    read_at(0, d);
    n_tests++; if ({pkt_vld, pkt_len, d} !== 13'h115A) begin n_fail++; $display("FAIL post_reset_frame: vld/len/rd got %h want 115a", {pkt_vld, pkt_len, d}); end
  endtask

  task automatic test_random();
    logic [7:0] q[$];
    logic [7:0] d;
    logic [7:0] s;
    int kind, ln, gap;
    for (int f = 0; f < 150; f++) begin
      q.delete();
      kind = $urandom_range(0, 5);
      if (kind == 0) begin
        for (int i = 0; i < int'($urandom_range(1, 2)); i++) begin
          d = 8'($urandom_range(0, 255));
          if (d == HDR) d = 8'h00;
          q.push_back(d);
        end
      end else if (kind == 5) begin
        q.push_back(HDR);
        q.push_back(($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(MAX_LEN + 1, 255)));
      end else begin
        ln = $urandom_range(1, MAX_LEN);
        q.push_back(HDR);
        q.push_back(8'(ln));
        s = 8'(ln);
        for (int i = 0; i < ln; i++) begin
          d = ($urandom_range(0, 7) == 0) ? HDR : 8'($urandom_range(0, 255));
          q.push_back(d);
          s = s ^ d;
        end
        if (kind == 4) s = s ^ 8'($urandom_range(1, 255));
        q.push_back(s);
      end
      foreach (q[i]) begin
        drive(q[i]);
        n_tests++; if ({pkt_vld, pkt_err} !== {exp_vld, exp_err}) begin n_fail++; $display("FAIL rnd_pulses f%0d: vld/err got %b want %b", f, {pkt_vld, pkt_err}, {exp_vld, exp_err}); end
        n_tests++; if (err_code !== exp_code) begin n_fail++; $display("FAIL rnd_code f%0d: got %0d want %0d", f, err_code, exp_code); end
        n_tests++; if (pkt_len !== exp_len) begin n_fail++; $display("FAIL rnd_len f%0d: got %0d want %0d", f, pkt_len, exp_len); end
        n_tests++; if (busy !== (cur.size() != 0)) begin n_fail++; $display("FAIL rnd_busy f%0d: got %b want %b", f, busy, cur.size() != 0); end
        if (any_commit) begin
          for (int a = 0; a < int'(exp_len); a++) begin
            read_at(a, d);
            n_tests++; if (d !== exp_pl[a]) begin n_fail++; $display("FAIL rnd_rd f%0d[%0d]: got %h want %h", f, a, d, exp_pl[a]); end
          end
        end
        gap = $urandom_range(0, 2);
        for (int g = 0; g < gap; g++) begin
          @(posedge clk_40k); #1;
          n_tests++; if ({pkt_vld, pkt_err} !== 2'b00) begin n_fail++; $display("FAIL rnd_gap_pulse f%0d: vld/err got %b want 00", f, {pkt_vld, pkt_err}); end
        end
      end
    end
  endtask

  initial begin
    repeat (2) @(posedge clk_40k);
    #1;
    test_reset();
    test_good_packet();
    test_bad_checksum();
    test_bad_length();
    test_timeout();
    test_pingpong();
    test_noise_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation still running at time %0t, limit 5000000", $time);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/uart_pkt_ctrl.md
Name: uart_pkt_ctrl

Overview:
Packet-level controller that sits directly behind the UART byte receiver and sequences its byte stream into framed command packets. Frame format: header, length, payload, checksum. Payload is stored in a ping-pong buffer. Good packets are committed and announced with a one-cycle pulse. Malformed, corrupted or stalled frames are dropped and reported, and the parser resynchronises on the next header.

Parameters:
HDR, 8'hA5, frame header byte
MAX_LEN, 8, maximum payload length in bytes (1..15)
TIMEOUT, 1200, inter-byte timeout in clk_40k cycles (3 byte times at 1000 bps)

Ports:
clk_40k  input  1  system clock, 40 kHz
rst_n  input  1  asynchronous reset, active low
rx_vld  input  1  one-cycle byte strobe from receiver
rx_data  input  8  received byte, valid when rx_vld=1
rd_addr  input  4  payload read index into committed bank
rd_data  output  8  committed payload byte at rd_addr (combinational read)
pkt_len  output  4  length of last committed packet
pkt_vld  output  1  one-cycle pulse: new packet committed
pkt_err  output  1  one-cycle pulse: frame dropped
err_code  output  2  cause of last drop: 1=bad length, 2=checksum, 3=timeout
busy  output  1  high when state != IDLE

Behaviour:
- One clock: clk_40k. Reset: asynchronous, active-low rst_n.
- Reset values:
  - pkt_len=0, pkt_vld=0, pkt_err=0, err_code=0, busy=0.
  - State=IDLE, active bank=0, timer=0, checksum=0.
  - Buffer contents are undefined after reset; rd_data is don't-care until the first pkt_vld.
- State machine (IDLE, LEN, PAYLOAD, CSUM):
  - IDLE: on rx_vld with rx_data==HDR, go to LEN. Non-header bytes are discarded silently, with no pkt_err.
  - LEN: on rx_vld, if rx_data is 0 or greater than MAX_LEN, pulse pkt_err with err_code=1 and go to IDLE. Otherwise latch len, set checksum=rx_data, set idx=0, go to PAYLOAD.
  - PAYLOAD: on rx_vld, write rx_data to the working bank at idx, XOR it into checksum, increment idx. When idx reaches len-1 on this write, go to CSUM.
  - CSUM: on rx_vld:
    - If rx_data == checksum: swap banks (working becomes committed), set pkt_len=len, pulse pkt_vld.
    - Else: pulse pkt_err with err_code=2.
    - Either way, go to IDLE.
- Checksum arithmetic: 8-bit XOR of the length byte and all payload bytes. The header is excluded.
- Latency: pkt_vld / pkt_err are registered and high for exactly the cycle after the rx_vld cycle that decides the outcome.
- Commit ordering: pkt_len, rd_data and the bank swap are visible in the same cycle pkt_vld is high.
- Committed-bank isolation: the committed bank is never written. A frame in progress only writes the other bank, so rd_data stays stable until the next pkt_vld.
- err_code holds its value until the next pkt_err. It is unaffected by pkt_vld.
- Timeout timer:
  - Runs only outside IDLE.
  - Cleared on every rx_vld and on entering IDLE.
  - When it reaches TIMEOUT-1 with no rx_vld, pulse pkt_err with err_code=3 and go to IDLE.
  - If rx_vld arrives in the same cycle the timer expires, the byte wins: it is processed and the timer clears.
- Header inside a frame: an HDR byte received in LEN, PAYLOAD or CSUM is treated as ordinary data. There is no resync mid-frame.
- After an error: the byte that caused the error is consumed. Parsing restarts only on the next HDR byte.
- rd_addr >= pkt_len: returns stale bank contents. Not an error.
- Reset mid-frame: the frame is abandoned, with no pulse. After reset the active bank is 0.

Test Plan:
- Good packet: A5 03 11 22 33 + checksum (03^11^22^33=03) -> pkt_vld one cycle after the checksum strobe; pkt_len=3; rd_data at addr 0..2 reads 11, 22, 33.
- Bad checksum: A5 02 10 20 FF (expected 32) -> pkt_err pulse, err_code=2; pkt_len and previous payload unchanged; busy=0.
- Bad length: A5 00 and A5 09 (MAX_LEN=8) -> pkt_err, err_code=1 in both cases; the next valid frame is accepted normally.
- Timeout: A5 04 01, then silence for 1200 cycles -> pkt_err, err_code=3 exactly TIMEOUT cycles after the last strobe; a byte arriving in the expiry cycle prevents the error.
- Ping-pong isolation: commit packet P1 (len 2: AA BB), then send A5 02 CC and stall before completing P2 -> rd_data still reads AA, BB throughout.
- Noise and reset: bytes 00 FF 5A before a header -> no pulses; assert rst_n low mid-PAYLOAD -> all outputs return to reset values and no pulse is emitted.
